// File: rtl/accum_alu_seq.sv
// Accumulator calculator: single-cycle ADD/SUB/CLR ops plus iterative
// shift-add multiply and restoring divide, behind a START/BUSY/DONE handshake.
module accum_alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [WIDTH-1:0]   IN1,
    input  logic [3:0]         OP,
    input  logic               START,
    output logic               BUSY,
    output logic               DONE,
    output logic [2*WIDTH-1:0] OUT,
    output logic [1:0]         ERR
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_CLR   = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_MUL   = 4'b0100;
    localparam logic [3:0] OP_DIV   = 4'b0101;
    localparam logic [3:0] OP_MOD   = 4'b0110;
    localparam logic [3:0] OP_RESET = 4'b1111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_ITER = 2'd1,
        DIV_ITER = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   out_q, out_d;
    logic [1:0]      err_q, err_d;
    logic            done_q, done_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      op_q, op_d;
    logic [DW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [DW-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic [WIDTH-1:0] fbk;
    logic             lastIter;
    logic [DW-1:0]    prodStep;
    logic [WIDTH:0]   remShift;
    logic             remGeq;
    logic [WIDTH-1:0] remDiff;
    logic [WIDTH-1:0] remNext;
    logic [WIDTH-1:0] quoNext;

    assign fbk      = out_q[WIDTH-1:0];
    assign lastIter = (cnt_q == CW'(WIDTH - 1));

    // One iteration of the shift-add multiplier and the restoring divider.
    always_comb begin
        prodStep = prod_q + (mplier_q[0] ? mcand_q : '0);
        remShift = {rem_q, quo_q[WIDTH-1]};
        remGeq   = (remShift >= {1'b0, divisor_q});
        // When the trial subtraction succeeds the true difference is below
        // the divisor, so the low WIDTH bits hold it exactly.
        remDiff  = remShift[WIDTH-1:0] - divisor_q;
        remNext  = remGeq ? remDiff : remShift[WIDTH-1:0];
        quoNext  = {quo_q[WIDTH-2:0], remGeq};
    end

    // Next-state logic: accept requests in IDLE, iterate in MUL/DIV, write back.
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        err_d     = err_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        op_d      = op_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;

        unique case (state_q)
            IDLE: begin
                if (START) begin
                    op_d   = OP;
                    cnt_d  = '0;
                    err_d  = 2'b00;
                    done_d = 1'b1;
                    case (OP)
                        OP_NOP: out_d = out_q;
                        OP_CLR: out_d = '0;
                        OP_ADD: out_d = {{WIDTH{1'b0}}, IN1} + {{WIDTH{1'b0}}, fbk};
                        OP_SUB: begin
                            out_d = {{WIDTH{1'b0}}, IN1} - {{WIDTH{1'b0}}, fbk};
                            err_d = {1'b0, (IN1 < fbk)};
                        end
                        OP_MUL: begin
                            done_d   = 1'b0;
                            err_d    = err_q;
                            mcand_d  = {{WIDTH{1'b0}}, IN1};
                            mplier_d = fbk;
                            prod_d   = '0;
                            state_d  = MUL_ITER;
                        end
                        OP_DIV, OP_MOD: begin
                            if (fbk == '0) begin
                                out_d = '0;
                                err_d = 2'b10;
                            end else begin
                                done_d    = 1'b0;
                                err_d     = err_q;
                                quo_d     = IN1;
                                divisor_d = fbk;
                                rem_d     = '0;
                                state_d   = DIV_ITER;
                            end
                        end
                        OP_RESET: out_d = '0;
                        default:  out_d = '0;
                    endcase
                end
            end

            MUL_ITER: begin
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                prod_d   = prodStep;
                cnt_d    = cnt_q + 1'b1;
                if (lastIter) begin
                    out_d   = prodStep;
                    err_d   = 2'b00;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            DIV_ITER: begin
                rem_d = remNext;
                quo_d = quoNext;
                cnt_d = cnt_q + 1'b1;
                if (lastIter) begin
                    out_d   = (op_q == OP_MOD) ? {{WIDTH{1'b0}}, remNext}
                                               : {{WIDTH{1'b0}}, quoNext};
                    err_d   = 2'b00;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset that aborts any iteration.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            out_q     <= '0;
            err_q     <= 2'b00;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            op_q      <= OP_NOP;
            mcand_q   <= '0;
            mplier_q  <= '0;
            prod_q    <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            err_q     <= err_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            prod_q    <= prod_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
        end
    end

    assign BUSY = (state_q != IDLE);
    assign DONE = done_q;
    assign OUT  = out_q;
    assign ERR  = err_q;

endmodule

// File: tb/tb_accum_alu_seq.sv
// Scoreboard bench for accum_alu_seq: directed ops push expected results,
// a DONE-driven monitor pops and compares them.
module tb_accum_alu_seq;

    localparam int W = 16;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_CLR   = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_MUL   = 4'b0100;
    localparam logic [3:0] OP_DIV   = 4'b0101;
    localparam logic [3:0] OP_MOD   = 4'b0110;
    localparam logic [3:0] OP_RESET = 4'b1111;

    logic           CLK = 1'b0;
    logic           RST;
    logic [W-1:0]   IN1;
    logic [3:0]     OP;
    logic           START;
    logic           BUSY;
    logic           DONE;
    logic [2*W-1:0] OUT;
    logic [1:0]     ERR;

    logic [2*W+1:0] expQ[$];
    int compared   = 0;
    int mismatched = 0;

    accum_alu_seq #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .IN1   (IN1),
        .OP    (OP),
        .START (START),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .OUT   (OUT),
        .ERR   (ERR)
    );

    // Free-running clock.
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest pending expectation.
    always @(negedge CLK) begin
        if (!RST && DONE) begin
            checkOutput("doneWithBusy", {31'b0, BUSY}, 32'd0);
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpectedDone: got OUT=%h ERR=%b, expected no DONE", OUT, ERR);
            end else begin
                logic [2*W+1:0] e;
                e = expQ.pop_front();
                checkOutput("out", OUT, e[2*W-1:0]);
                checkOutput("err", {30'b0, ERR}, {30'b0, e[2*W+1:2*W]});
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] in1,
                                 input bit expectDone, input logic [31:0] expOut,
                                 input logic [1:0] expErr);
        @(negedge CLK);
        if (expectDone) expQ.push_back({expErr, expOut});
        START = 1'b1;
        OP    = op;
        IN1   = in1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        OP    = OP_ADD;
        IN1   = 16'hDEAD;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        do begin
            @(negedge CLK);
            #1;
            n++;
        end while ((BUSY || expQ.size() != 0) && n < 40);
        checkOutput({name, "_idle"}, {30'b0, BUSY, (expQ.size() != 0)}, 32'd0);
    endtask

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        RST   = 1'b1;
        START = 1'b0;
        OP    = OP_NOP;
        IN1   = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checkOutput("rstOut",  OUT, 32'd0);
        checkOutput("rstErr",  {30'b0, ERR}, 32'd0);
        checkOutput("rstBusy", {31'b0, BUSY}, 32'd0);
        checkOutput("rstDone", {31'b0, DONE}, 32'd0);
        RST = 1'b0;

        // Basic accumulate and wrapping subtract.
        applyStimulus(OP_ADD, 16'd11, 1, 32'd11, 2'b00);
        waitIdle("add11");
        applyStimulus(OP_ADD, 16'd15, 1, 32'd26, 2'b00);
        waitIdle("add15");
        applyStimulus(OP_SUB, 16'd5, 1, 32'hFFFF_FFEB, 2'b01);
        waitIdle("sub5");
        applyStimulus(OP_CLR, 16'd0, 1, 32'd0, 2'b00);
        waitIdle("clr");

        // Back-to-back single-cycle ops, NOP, unused opcode.
        applyStimulus(OP_ADD, 16'd5, 1, 32'd5, 2'b00);
        applyStimulus(OP_ADD, 16'd7, 1, 32'd12, 2'b00);
        applyStimulus(OP_NOP, 16'd99, 1, 32'd12, 2'b00);
        applyStimulus(4'b1001, 16'd3, 1, 32'd0, 2'b00);
        waitIdle("b2b");

        // RESET opcode clears a borrow flag.
        applyStimulus(OP_ADD, 16'd3, 1, 32'd3, 2'b00);
        applyStimulus(OP_SUB, 16'd1, 1, 32'hFFFF_FFFE, 2'b01);
        applyStimulus(OP_RESET, 16'd0, 1, 32'd0, 2'b00);
        waitIdle("resetop");

        // Multiply timing: OUT held while BUSY, mid-iteration START ignored.
        applyStimulus(OP_ADD, 16'd300, 1, 32'd300, 2'b00);
        waitIdle("add300");
        applyStimulus(OP_MUL, 16'd1000, 1, 32'd300000, 2'b00);
        for (int i = 0; i < W; i++) begin
            @(negedge CLK);
            checkOutput("mulBusy", {31'b0, BUSY}, 32'd1);
            checkOutput("mulHold", OUT, 32'd300);
            if (i == 2) begin
                START = 1'b1;
                OP    = OP_CLR;
            end
            if (i == 3) START = 1'b0;
        end
        @(negedge CLK);
        #1;
        checkOutput("mulEndBusy", {31'b0, BUSY}, 32'd0);
        waitIdle("mul");

        // Divide and modulo.
        applyStimulus(OP_CLR, 16'd0, 1, 32'd0, 2'b00);
        applyStimulus(OP_ADD, 16'd7, 1, 32'd7, 2'b00);
        waitIdle("add7");
        applyStimulus(OP_DIV, 16'd1000, 1, 32'd142, 2'b00);
        waitIdle("div");
        applyStimulus(OP_MOD, 16'd1000, 1, 32'd6, 2'b00);
        waitIdle("mod");

        // Divide/modulo by zero complete in one cycle with ERR[1].
        applyStimulus(OP_CLR, 16'd0, 1, 32'd0, 2'b00);
        waitIdle("clr2");
        applyStimulus(OP_DIV, 16'd9, 1, 32'd0, 2'b10);
        @(negedge CLK);
        checkOutput("div0Busy", {31'b0, BUSY}, 32'd0);
        waitIdle("div0");
        applyStimulus(OP_MOD, 16'd9, 1, 32'd0, 2'b10);
        waitIdle("mod0");
        applyStimulus(OP_ADD, 16'd2, 1, 32'd2, 2'b00);
        waitIdle("add2");
        applyStimulus(OP_DIV, 16'd1, 1, 32'd0, 2'b00);
        waitIdle("divSmall");

        // Multiply boundaries: by zero and full-width operands, then carry.
        applyStimulus(OP_MUL, 16'd1234, 1, 32'd0, 2'b00);
        waitIdle("mulZero");
        applyStimulus(OP_ADD, 16'hFFFF, 1, 32'h0000_FFFF, 2'b00);
        waitIdle("addMax");
        applyStimulus(OP_MUL, 16'hFFFF, 1, 32'hFFFE_0001, 2'b00);
        waitIdle("mulMax");
        applyStimulus(OP_ADD, 16'hFFFF, 1, 32'h0001_0000, 2'b00);
        waitIdle("addCarry");

        // Reset during a multiply aborts it without DONE.
        applyStimulus(OP_CLR, 16'd0, 1, 32'd0, 2'b00);
        applyStimulus(OP_ADD, 16'd300, 1, 32'd300, 2'b00);
        waitIdle("add300b");
        applyStimulus(OP_MUL, 16'd1000, 0, 32'd0, 2'b00);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (i == 4) RST = 1'b1;
        end
        @(negedge CLK);
        checkOutput("abortOut",  OUT, 32'd0);
        checkOutput("abortBusy", {31'b0, BUSY}, 32'd0);
        checkOutput("abortErr",  {30'b0, ERR}, 32'd0);
        checkOutput("abortDone", {31'b0, DONE}, 32'd0);
        RST = 1'b0;
        repeat (W + 2) @(negedge CLK);
        applyStimulus(OP_ADD, 16'd4, 1, 32'd4, 2'b00);
        waitIdle("add4");

        checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
